// File: rtl/wm_pkg.sv
// wm_pkg: shared types and constants for the coin credit controller.
// Rev 1.0
`default_nettype none

package wm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ARMED   = 2'd2,
    ST_REFUND  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_1   = 2'b00,
    COIN_2   = 2'b01,
    COIN_5   = 2'b10,
    COIN_BAD = 2'b11
  } coin_code_t;

  localparam logic [3:0] COIN_1_UNITS = 4'd1;
  localparam logic [3:0] COIN_2_UNITS = 4'd2;
  localparam logic [3:0] COIN_5_UNITS = 4'd5;

  localparam int SINGLE_PRICE_DEF = 4;
  localparam int DOUBLE_PRICE_DEF = 6;
  localparam int TIMEOUT_DEF      = 16;

  function automatic logic [3:0] coin_units(input coin_code_t code);
    case (code)
      COIN_1:  coin_units = COIN_1_UNITS;
      COIN_2:  coin_units = COIN_2_UNITS;
      COIN_5:  coin_units = COIN_5_UNITS;
      default: coin_units = 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/coin_timeout_timer.sv
// coin_timeout_timer: counts enabled cycles, strobes expired on the TIMEOUT-th one.
// Rev 1.0
`default_nettype none

module coin_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expired ? '0 : count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/coin_credit_ctrl.sv
// coin_credit_ctrl: accumulates coin credit, arms the washer at price, refunds change/cancel/timeout.
// Rev 1.0
`default_nettype none

module coin_credit_ctrl
  import wm_pkg::*;
#(
  parameter int SINGLE_PRICE = SINGLE_PRICE_DEF,
  parameter int DOUBLE_PRICE = DOUBLE_PRICE_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_value_i,
  input  logic       double_wash_req_i,
  input  logic       cancel_i,
  input  logic       wm_done_i,
  output logic       coin_deposit_o,
  output logic       double_wash_o,
  output logic [3:0] credit_o,
  output logic       refund_valid_o,
  output logic [3:0] refund_amount_o,
  output logic       reject_o
);

  state_t     state;
  coin_code_t code;
  logic [4:0] sum;
  logic [4:0] price;
  logic [3:0] change;
  logic       coin_ok;
  logic       pays;
  logic       tmr_clear;
  logic       tmr_enable;
  logic       expired;

  assign code = coin_code_t'(coin_value_i);

  // Sum is one bit wider so an overflow past 15 shows up as a carry and rejects the coin.
  always_comb begin
    price   = double_wash_req_i ? 5'(DOUBLE_PRICE) : 5'(SINGLE_PRICE);
    sum     = {1'b0, credit_o} + {1'b0, coin_units(code)};
    coin_ok = coin_valid_i && (code != COIN_BAD) && !sum[4];
    pays    = coin_ok && (sum >= price);
    change  = sum[3:0] - price[3:0];
  end

  assign tmr_enable = (state == ST_COLLECT);
  assign tmr_clear  = (state != ST_COLLECT) || coin_valid_i || cancel_i;

  coin_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      coin_deposit_o  <= 1'b0;
      double_wash_o   <= 1'b0;
      credit_o        <= 4'd0;
      refund_valid_o  <= 1'b0;
      refund_amount_o <= 4'd0;
      reject_o        <= 1'b0;
    end else begin
      refund_valid_o  <= 1'b0;
      refund_amount_o <= 4'd0;
      reject_o        <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          reject_o <= coin_valid_i && !coin_ok;
          if (pays) begin
            state           <= ST_ARMED;
            coin_deposit_o  <= 1'b1;
            double_wash_o   <= double_wash_req_i;
            credit_o        <= 4'd0;
            refund_valid_o  <= 1'b1;
            refund_amount_o <= change;
          end else if ((state == ST_COLLECT) && (cancel_i || expired)) begin
            // A same-cycle coin is credited before the refund is computed.
            state           <= ST_REFUND;
            credit_o        <= 4'd0;
            refund_valid_o  <= 1'b1;
            refund_amount_o <= coin_ok ? sum[3:0] : credit_o;
          end else if (coin_ok) begin
            state    <= ST_COLLECT;
            credit_o <= sum[3:0];
          end
        end
        ST_ARMED: begin
          reject_o <= coin_valid_i;
          if (wm_done_i) begin
            state          <= ST_IDLE;
            coin_deposit_o <= 1'b0;
            double_wash_o  <= 1'b0;
          end
        end
        ST_REFUND: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coin_credit_ctrl.sv
// tb_coin_credit_ctrl: directed self-checking bench for coin_credit_ctrl (prices 4/6, timeout 16).
// Rev 1.0
`default_nettype none

module tb_coin_credit_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid_i = 1'b0;
  logic [1:0] coin_value_i = 2'b00;
  logic       double_wash_req_i = 1'b0;
  logic       cancel_i = 1'b0;
  logic       wm_done_i = 1'b0;
  logic       coin_deposit_o;
  logic       double_wash_o;
  logic [3:0] credit_o;
  logic       refund_valid_o;
  logic [3:0] refund_amount_o;
  logic       reject_o;

  int total = 0;
  int bad   = 0;

  coin_credit_ctrl #(
    .SINGLE_PRICE (4),
    .DOUBLE_PRICE (6),
    .TIMEOUT      (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .coin_valid_i      (coin_valid_i),
    .coin_value_i      (coin_value_i),
    .double_wash_req_i (double_wash_req_i),
    .cancel_i          (cancel_i),
    .wm_done_i         (wm_done_i),
    .coin_deposit_o    (coin_deposit_o),
    .double_wash_o     (double_wash_o),
    .credit_o          (credit_o),
    .refund_valid_o    (refund_valid_o),
    .refund_amount_o   (refund_amount_o),
    .reject_o          (reject_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid_i = 1'b1;
    coin_value_i = v;
    cycle();
    coin_valid_i = 1'b0;
  endtask

  initial begin
    // reset state
    cycle();
    cycle();
    chk("rst_deposit", 8'(coin_deposit_o), 8'd0);
    chk("rst_credit", 8'(credit_o), 8'd0);
    chk("rst_refund", 8'(refund_valid_o), 8'd0);
    chk("rst_reject", 8'(reject_o), 8'd0);
    rst = 1'b1;

    // 2 + 2, single wash: exact payment
    coin(2'b01);
    chk("s_credit2", 8'(credit_o), 8'd2);
    chk("s_dep_early", 8'(coin_deposit_o), 8'd0);
    coin(2'b01);
    chk("s_deposit", 8'(coin_deposit_o), 8'd1);
    chk("s_rvalid", 8'(refund_valid_o), 8'd1);
    chk("s_ramount", 8'(refund_amount_o), 8'd0);
    chk("s_double", 8'(double_wash_o), 8'd0);
    chk("s_credit0", 8'(credit_o), 8'd0);
    cycle();
    chk("s_rvalid_drop", 8'(refund_valid_o), 8'd0);
    chk("s_dep_hold", 8'(coin_deposit_o), 8'd1);
    wm_done_i = 1'b1;
    cycle();
    wm_done_i = 1'b0;
    chk("s_done_dep", 8'(coin_deposit_o), 8'd0);

    // 5 + 2, double wash: change 1
    double_wash_req_i = 1'b1;
    coin(2'b10);
    chk("d_credit5", 8'(credit_o), 8'd5);
    coin(2'b01);
    chk("d_deposit", 8'(coin_deposit_o), 8'd1);
    chk("d_double", 8'(double_wash_o), 8'd1);
    chk("d_ramount", 8'(refund_amount_o), 8'd1);
    double_wash_req_i = 1'b0;
    cycle();
    chk("d_double_hold", 8'(double_wash_o), 8'd1);
    coin(2'b00);
    chk("armed_reject", 8'(reject_o), 8'd1);
    chk("armed_credit", 8'(credit_o), 8'd0);
    wm_done_i = 1'b1;
    cycle();
    wm_done_i = 1'b0;
    chk("d_done_dep", 8'(coin_deposit_o), 8'd0);
    chk("d_done_dbl", 8'(double_wash_o), 8'd0);

    // 1 + 2, invalid code, cancel
    coin(2'b00);
    coin(2'b01);
    chk("c_credit3", 8'(credit_o), 8'd3);
    coin(2'b11);
    chk("c_reject", 8'(reject_o), 8'd1);
    chk("c_credit_kept", 8'(credit_o), 8'd3);
    cancel_i = 1'b1;
    cycle();
    cancel_i = 1'b0;
    chk("c_rvalid", 8'(refund_valid_o), 8'd1);
    chk("c_ramount", 8'(refund_amount_o), 8'd3);
    chk("c_credit0", 8'(credit_o), 8'd0);
    cycle();
    chk("c_rvalid_drop", 8'(refund_valid_o), 8'd0);
    chk("c_ramount0", 8'(refund_amount_o), 8'd0);
    cancel_i = 1'b1;
    cycle();
    cancel_i = 1'b0;
    chk("idle_cancel", 8'(refund_valid_o), 8'd0);

    // coin 2 then timeout after 16 idle cycles
    coin(2'b01);
    for (int i = 0; i < 15; i++) cycle();
    chk("t_not_yet", 8'(refund_valid_o), 8'd0);
    chk("t_credit2", 8'(credit_o), 8'd2);
    cycle();
    chk("t_rvalid", 8'(refund_valid_o), 8'd1);
    chk("t_ramount", 8'(refund_amount_o), 8'd2);
    chk("t_credit0", 8'(credit_o), 8'd0);
    cycle();

    // coin reaching price with cancel: coin wins
    coin(2'b01);
    cancel_i = 1'b1;
    coin(2'b01);
    cancel_i = 1'b0;
    chk("cw_deposit", 8'(coin_deposit_o), 8'd1);
    chk("cw_ramount", 8'(refund_amount_o), 8'd0);
    cycle();
    chk("cw_armed_hold", 8'(coin_deposit_o), 8'd1);
    wm_done_i = 1'b1;
    cycle();
    wm_done_i = 1'b0;

    // coin below price with cancel: credited then refunded
    coin(2'b00);
    cancel_i = 1'b1;
    coin(2'b00);
    cancel_i = 1'b0;
    chk("cc_ramount", 8'(refund_amount_o), 8'd2);
    chk("cc_deposit", 8'(coin_deposit_o), 8'd0);
    cycle();

    // async reset mid-collect, then first coin after release
    coin(2'b01);
    chk("r_credit2", 8'(credit_o), 8'd2);
    #2 rst = 1'b0;
    #1;
    chk("r_credit_async", 8'(credit_o), 8'd0);
    chk("r_no_refund", 8'(refund_valid_o), 8'd0);
    #1 rst = 1'b1;
    coin(2'b10);
    chk("r_deposit", 8'(coin_deposit_o), 8'd1);
    chk("r_rvalid", 8'(refund_valid_o), 8'd1);
    chk("r_ramount", 8'(refund_amount_o), 8'd1);
    #2 rst = 1'b0;
    #1;
    chk("r_armed_drop", 8'(coin_deposit_o), 8'd0);
    #1 rst = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/coin_credit_ctrl.md
COIN_CREDIT_CTRL -- requirements
Module: coin_credit_ctrl

Interface
REQ-001: Parameter SINGLE_PRICE, default 4, credit units for a single wash.
REQ-002: Parameter DOUBLE_PRICE, default 6, credit units for a double wash.
REQ-003: Parameter TIMEOUT, default 16, idle cycles in COLLECT before auto-refund.
REQ-004: clk  input  1  single clock, all state updates on rising edge.
REQ-005: rst  input  1  asynchronous, active-low reset.
REQ-006: coin_valid_i  input  1  one-cycle strobe, one coin presented.
REQ-007: coin_value_i  input  2  coin code: 00=1 unit, 01=2, 10=5, 11=invalid.
REQ-008: double_wash_req_i  input  1  user selects double wash, level.
REQ-009: cancel_i  input  1  one-cycle strobe, user cancels payment.
REQ-010: wm_done_i  input  1  done strobe from the washing machine FSM.
REQ-011: coin_deposit_o  output  1  level, payment complete, drives washing machine coin_deposit_i.
REQ-012: double_wash_o  output  1  level, latched wash selection, drives double_wash_i.
REQ-013: credit_o  output  4  current accumulated credit, 0..15.
REQ-014: refund_valid_o  output  1  one-cycle strobe, refund_amount_o is valid.
REQ-015: refund_amount_o  output  4  units returned, 0 when refund_valid_o=0.
REQ-016: reject_o  output  1  one-cycle strobe, presented coin not credited.

Function
REQ-017: States IDLE, COLLECT, ARMED, REFUND; all outputs registered.
REQ-018: Price = DOUBLE_PRICE if double_wash_req_i=1 in the evaluating cycle, else SINGLE_PRICE.
REQ-019: IDLE/COLLECT, valid coin, credit+value < price: credit_o = credit+value next cycle, state COLLECT, timeout counter cleared.
REQ-020: IDLE/COLLECT, valid coin, credit+value >= price: next cycle state ARMED, coin_deposit_o=1, double_wash_o latched, credit_o=0, refund_valid_o=1 with refund_amount_o = credit+value-price (strobe fires even when change is 0).
REQ-021: Coin code 11: reject_o=1 next cycle, credit unchanged.
REQ-022: Credit is never exceeded: 4-bit sum checked with carry; if credit+value > 15 the coin is rejected.
REQ-023: ARMED: every coin_valid_i gives reject_o; cancel_i and double_wash_req_i are ignored; coin_deposit_o and double_wash_o are held.
REQ-024: ARMED, wm_done_i=1: coin_deposit_o=0 and double_wash_o=0 next cycle, state IDLE.
REQ-025: COLLECT, cancel_i=1: state REFUND; a coin in the same cycle is credited first (REQ-022 still applies); the REFUND cycle drives refund_valid_o=1 with refund_amount_o = full credit; credit_o=0; then IDLE.
REQ-026: COLLECT, no coin for TIMEOUT consecutive cycles: same behaviour as cancel_i.
REQ-027: cancel_i in IDLE is ignored, with no refund strobe.
REQ-028: Coin and cancel_i in the same cycle where the coin reaches price: the coin wins, state ARMED, and cancel_i is dropped.
REQ-029: wm_done_i outside ARMED is ignored.

Reset
REQ-030: rst=0 asynchronously forces IDLE, credit 0, timeout counter 0, and all outputs 0.
REQ-031: Reset mid-COLLECT discards credit with no refund strobe; reset in ARMED drops coin_deposit_o at once.
REQ-032: After rst rises, the first coin is accepted on the first clock edge.

Structure
REQ-033: Shared package wm_pkg holds the state enum, the coin-code enum, the coin-value lookup constants, and the price defaults.
REQ-034: One sub-module, coin_timeout_timer: clear, enable, and expired strobe at TIMEOUT.

Verification
REQ-035: Coins 2,2 with double_wash_req_i=0 -> second coin: coin_deposit_o=1 next cycle, refund 0, double_wash_o=0.
REQ-036: Coins 5,2 with double_wash_req_i=1 -> after the 2: coin_deposit_o=1, double_wash_o=1, refund_amount_o=1; wm_done_i -> both outputs low next cycle.
REQ-037: Coin 1, coin 2, then cancel_i -> refund_valid_o one cycle, refund_amount_o=3, credit_o=0; code 11 -> reject_o, credit unchanged.
REQ-038: Coin 2, then 16 idle cycles -> refund_amount_o=2 on expiry; coin in ARMED -> reject_o, credit stays 0.
REQ-039: Coin 2, then rst pulse low mid-cycle -> outputs 0 immediately, no refund strobe; a following coin 5 gives ARMED with refund 1.
